// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Multi-domain reset generator sitting between the board reset pin and the
// core. All CHANNELS active-low reset outputs are asserted asynchronously when
// reset_n goes low. After reset_n rises the release is synchronised, a
// hold-off elapses, and the channels are released one at a time in ascending
// order with a fixed gap between them. Software can re-reset any non-empty
// subset of channels while the block is idle; unselected channels stay
// released throughout.
//
// Parameters
//   CHANNELS       number of reset outputs (1..32)
//   SYNC_STAGES    synchroniser depth on the reset_n release path (>= 2)
//   HOLDOFF_CYCLES cycles of synchronised reset high before the first release;
//                  also the software-reset hold time (>= 1)
//   RELEASE_GAP    cycles between consecutive channel releases (>= 1)
//
// Ports
//   clk            single clock for all logic
//   reset_n        raw board reset, asynchronous, active-low
//   sw_reset_req   software reset request, level-sampled on clk
//   sw_reset_mask  channels to re-reset, sampled together with sw_reset_req
//   nreset         active-low channel resets, bit 0 released first (registered)
//   ready          high when every channel is released and the block is idle
//                  (registered)
// -----------------------------------------------------------------------------
module reset_sequencer #(
    parameter int CHANNELS       = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int HOLDOFF_CYCLES = 4,
    parameter int RELEASE_GAP    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sw_reset_req,
    input  logic [CHANNELS-1:0] sw_reset_mask,
    output logic [CHANNELS-1:0] nreset,
    output logic                ready
);

    localparam int MAX_CNT = (HOLDOFF_CYCLES > RELEASE_GAP) ? HOLDOFF_CYCLES : RELEASE_GAP;
    localparam int CW      = $clog2(MAX_CNT + 1);

    // Terminal counts. The software hold starts counting on the edge after the
    // request, so it ends at HOLDOFF_CYCLES-1. The power-on hold-off is entered
    // one edge after the synchroniser output is first seen high, and that
    // observing edge already counts as the first hold-off cycle, so the
    // HOLDOFF state ends one count earlier. With HOLDOFF_CYCLES == 1 the
    // HOLDOFF state is skipped entirely and HOLD_PWR_LAST is never used.
    localparam logic [CW-1:0] HOLD_LAST     = CW'(HOLDOFF_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_PWR_LAST = CW'(HOLDOFF_CYCLES - 2);
    localparam logic [CW-1:0] GAP_LAST      = CW'(RELEASE_GAP - 1);

    typedef enum logic [2:0] {
        ST_SYNC       = 3'd0,
        ST_HOLDOFF    = 3'd1,
        ST_RELEASE    = 3'd2,
        ST_IDLE       = 3'd3,
        ST_SW_HOLD    = 3'd4,
        ST_SW_RELEASE = 3'd5
    } state_t;

    // Isolate the lowest set bit of a channel vector (two's complement trick).
    function automatic logic [CHANNELS-1:0] f_lowest_set(input logic [CHANNELS-1:0] v);
        return v & ((~v) + CHANNELS'(1));
    endfunction

    // Registers
    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [CHANNELS-1:0]    r_pend;     // channels still waiting to be released
    logic [CHANNELS-1:0]    r_nreset;
    logic                   r_ready;

    // Next-state / helper wires
    state_t                 w_state_n;
    logic [CW-1:0]          w_cnt_n;
    logic [CHANNELS-1:0]    w_pend_n;
    logic [CHANNELS-1:0]    w_nreset_n;
    logic                   w_ready_n;
    logic                   w_sync_out;
    logic [CHANNELS-1:0]    w_low;
    logic [CHANNELS-1:0]    w_rel_nreset;
    logic [CHANNELS-1:0]    w_rel_pend;
    logic                   w_rel_last;

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    // A release step always frees the lowest pending channel; whether it was
    // the last one decides between continuing and going idle.
    assign w_low        = f_lowest_set(r_pend);
    assign w_rel_nreset = r_nreset | w_low;
    assign w_rel_pend   = r_pend & ~w_low;
    assign w_rel_last   = (w_rel_pend == {CHANNELS{1'b0}});

    // Release-path synchroniser for the raw reset; cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= {SYNC_STAGES{1'b0}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Sequencer state, counter and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_SYNC;
            r_cnt    <= {CW{1'b0}};
            r_pend   <= {CHANNELS{1'b0}};
            r_nreset <= {CHANNELS{1'b0}};
            r_ready  <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_pend   <= w_pend_n;
            r_nreset <= w_nreset_n;
            r_ready  <= w_ready_n;
        end
    end

    // Next-state and next-output logic for the release sequencer.
    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_pend_n   = r_pend;
        w_nreset_n = r_nreset;
        w_ready_n  = r_ready;

        case (r_state)
            ST_SYNC: begin
                // Every channel is pending for the power-on release.
                w_pend_n = {CHANNELS{1'b1}};
                w_cnt_n  = {CW{1'b0}};
                if (w_sync_out) begin
                    if (HOLDOFF_CYCLES == 1) begin
                        // r_pend is already all-ones: it was loaded on edge 1
                        // and the synchroniser needs at least two edges.
                        w_nreset_n = w_rel_nreset;
                        w_pend_n   = w_rel_pend;
                        if (w_rel_last) begin
                            w_ready_n = 1'b1;
                            w_state_n = ST_IDLE;
                        end else begin
                            w_state_n = ST_RELEASE;
                        end
                    end else begin
                        w_state_n = ST_HOLDOFF;
                    end
                end else begin
                    w_state_n = ST_SYNC;
                end
            end

            ST_HOLDOFF: begin
                if (r_cnt == HOLD_PWR_LAST) begin
                    w_cnt_n    = {CW{1'b0}};
                    w_nreset_n = w_rel_nreset;
                    w_pend_n   = w_rel_pend;
                    if (w_rel_last) begin
                        w_ready_n = 1'b1;
                        w_state_n = ST_IDLE;
                    end else begin
                        w_state_n = ST_RELEASE;
                    end
                end else begin
                    w_cnt_n = r_cnt + CW'(1);
                end
            end

            ST_RELEASE, ST_SW_RELEASE: begin
                // Pending set only holds channels still to go, so unmasked
                // channels are skipped without consuming a gap.
                if (r_cnt == GAP_LAST) begin
                    w_cnt_n    = {CW{1'b0}};
                    w_nreset_n = w_rel_nreset;
                    w_pend_n   = w_rel_pend;
                    if (w_rel_last) begin
                        w_ready_n = 1'b1;
                        w_state_n = ST_IDLE;
                    end else begin
                        w_state_n = r_state;
                    end
                end else begin
                    w_cnt_n = r_cnt + CW'(1);
                end
            end

            ST_IDLE: begin
                w_ready_n = 1'b1;
                w_cnt_n   = {CW{1'b0}};
                if (sw_reset_req && (sw_reset_mask != {CHANNELS{1'b0}})) begin
                    w_nreset_n = r_nreset & ~sw_reset_mask;
                    w_ready_n  = 1'b0;
                    w_pend_n   = sw_reset_mask;
                    w_state_n  = ST_SW_HOLD;
                end else begin
                    w_state_n = ST_IDLE;
                end
            end

            ST_SW_HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_cnt_n    = {CW{1'b0}};
                    w_nreset_n = w_rel_nreset;
                    w_pend_n   = w_rel_pend;
                    if (w_rel_last) begin
                        w_ready_n = 1'b1;
                        w_state_n = ST_IDLE;
                    end else begin
                        w_state_n = ST_SW_RELEASE;
                    end
                end else begin
                    w_cnt_n = r_cnt + CW'(1);
                end
            end

            default: begin
                // Illegal encoding: fall back to a full, safe restart.
                w_state_n  = ST_SYNC;
                w_cnt_n    = {CW{1'b0}};
                w_pend_n   = {CHANNELS{1'b0}};
                w_nreset_n = {CHANNELS{1'b0}};
                w_ready_n  = 1'b0;
            end
        endcase
    end

    assign nreset = r_nreset;
    assign ready  = r_ready;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//
// Directed bench for reset_sequencer. A default-parameter instance covers
// power-on release, mid-sequence abort, software re-reset, ignored and held
// requests; a second instance covers the CHANNELS=1 / SYNC_STAGES=3 /
// HOLDOFF_CYCLES=1 / RELEASE_GAP=1 variant. Inputs change and outputs are
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          sw_reset_req;
    logic [CH-1:0] sw_reset_mask;
    logic [CH-1:0] nreset;
    logic          ready;

    logic          v_reset_n;
    logic          v_req;
    logic [0:0]    v_mask;
    logic [0:0]    v_nreset;
    logic          v_ready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .CHANNELS(4), .SYNC_STAGES(2), .HOLDOFF_CYCLES(4), .RELEASE_GAP(16)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .sw_reset_req(sw_reset_req),
        .sw_reset_mask(sw_reset_mask), .nreset(nreset), .ready(ready)
    );

    reset_sequencer #(
        .CHANNELS(1), .SYNC_STAGES(3), .HOLDOFF_CYCLES(1), .RELEASE_GAP(1)
    ) u_dut_v (
        .clk(clk), .reset_n(v_reset_n), .sw_reset_req(v_req),
        .sw_reset_mask(v_mask), .nreset(v_nreset), .ready(v_ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Power-on schedule with defaults: bit k rises at edge 2 + 4 + 16*k.
    function automatic logic [CH-1:0] exp_pwr(input int e);
        logic [CH-1:0] v;
        v = 4'b0000;
        for (int k = 0; k < CH; k++) begin
            if (e >= 6 + 16 * k) v[k] = 1'b1;
        end
        return v;
    endfunction

    // Software schedule k edges after the request edge: the r-th masked bit
    // (ascending) rises at k = 4 + 16*r; unmasked bits stay high.
    function automatic logic [CH-1:0] exp_sw(input logic [CH-1:0] mask, input int k);
        logic [CH-1:0] v;
        int r;
        v = 4'b0000;
        r = 0;
        for (int i = 0; i < CH; i++) begin
            if (!mask[i]) begin
                v[i] = 1'b1;
            end else begin
                v[i] = (k >= 4 + 16 * r);
                r++;
            end
        end
        return v;
    endfunction

    // Called at a falling edge with reset_n low; edge 1 is the next rising edge.
    // A mask-1111 request is driven for edges req_from..req_to.
    task automatic run_power_on(input string name, input int n_edges, input int req_from, input int req_to);
        reset_n = 1'b1;
        for (int e = 1; e <= n_edges; e++) begin
            sw_reset_req  = (e >= req_from) && (e <= req_to);
            sw_reset_mask = 4'b1111;
            step();
            check_eq($sformatf("%s nreset e%0d", name, e), nreset, exp_pwr(e));
            check_eq($sformatf("%s ready e%0d", name, e), ready, (e >= 54));
        end
        sw_reset_req  = 1'b0;
        sw_reset_mask = 4'b0000;
    endtask

    // Called at a falling edge with the block idle. The request edge is k=0;
    // a mask-1111 request is driven for edges ign_from..ign_to.
    task automatic run_sw(input string name, input logic [CH-1:0] mask, input int n_after,
                          input int ign_from, input int ign_to);
        logic [CH-1:0] e_v;
        sw_reset_req  = 1'b1;
        sw_reset_mask = mask;
        for (int k = 0; k <= n_after; k++) begin
            step();
            e_v = exp_sw(mask, k);
            check_eq($sformatf("%s nreset k%0d", name, k), nreset, e_v);
            check_eq($sformatf("%s ready k%0d", name, k), ready, &e_v);
            if ((k + 1 >= ign_from) && (k + 1 <= ign_to)) begin
                sw_reset_req  = 1'b1;
                sw_reset_mask = 4'b1111;
            end else begin
                sw_reset_req  = 1'b0;
                sw_reset_mask = 4'b0000;
            end
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        sw_reset_req  = 1'b0;
        sw_reset_mask = 4'b0000;
        v_reset_n     = 1'b0;
        v_req         = 1'b0;
        v_mask        = 1'b0;

        repeat (5) @(negedge clk);
        check_eq("rst nreset", nreset, 4'b0000);
        check_eq("rst ready", ready, 1'b0);
        check_eq("v rst nreset", v_nreset, 1'b0);
        check_eq("v rst ready", v_ready, 1'b0);

        // Power-on with defaults, plus idle edges afterwards.
        run_power_on("pwr", 64, 0, -1);

        // Asynchronous assertion from idle, then abort mid-sequence.
        reset_n = 1'b0;
        #1;
        check_eq("async idle nreset", nreset, 4'b0000);
        check_eq("async idle ready", ready, 1'b0);
        repeat (3) @(negedge clk);
        run_power_on("pre", 29, 0, -1);
        reset_n = 1'b0;
        #1;
        check_eq("abort nreset", nreset, 4'b0000);
        check_eq("abort ready", ready, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq($sformatf("abort hold nreset c%0d", c), nreset, 4'b0000);
            check_eq($sformatf("abort hold ready c%0d", c), ready, 1'b0);
        end
        run_power_on("restart", 60, 0, -1);

        // Software reset of channels 1 and 3.
        run_sw("sw1010", 4'b1010, 24, 0, -1);

        // Zero-mask request in idle is ignored.
        sw_reset_req  = 1'b1;
        sw_reset_mask = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq($sformatf("zmask nreset c%0d", c), nreset, 4'b1111);
            check_eq($sformatf("zmask ready c%0d", c), ready, 1'b1);
        end
        sw_reset_req = 1'b0;

        // Requests during SW_RELEASE are ignored and not queued.
        run_sw("swign", 4'b1010, 26, 5, 20);

        // Requests during the power-on sequence are ignored and not queued.
        reset_n = 1'b0;
        @(negedge clk);
        run_power_on("relign", 64, 1, 54);

        // Held request with mask 0001: 4 cycles low, 1 cycle ready, repeat.
        sw_reset_req  = 1'b1;
        sw_reset_mask = 4'b0001;
        for (int k = 0; k < 20; k++) begin
            step();
            check_eq($sformatf("held nreset k%0d", k), nreset, {3'b111, (k % 5 == 4)});
            check_eq($sformatf("held ready k%0d", k), ready, (k % 5 == 4));
        end
        sw_reset_req  = 1'b0;
        sw_reset_mask = 4'b0000;
        step();
        check_eq("held end nreset", nreset, 4'b1111);
        check_eq("held end ready", ready, 1'b1);

        // Parameter variant: release at edge 4, one-cycle software pulse.
        v_reset_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            check_eq($sformatf("v pwr nreset e%0d", e), v_nreset, (e >= 4));
            check_eq($sformatf("v pwr ready e%0d", e), v_ready, (e >= 4));
        end
        v_req  = 1'b1;
        v_mask = 1'b1;
        step();
        check_eq("v sw E nreset", v_nreset, 1'b0);
        check_eq("v sw E ready", v_ready, 1'b0);
        v_req  = 1'b0;
        v_mask = 1'b0;
        step();
        check_eq("v sw E+1 nreset", v_nreset, 1'b1);
        check_eq("v sw E+1 ready", v_ready, 1'b1);
        step();
        check_eq("v sw E+2 nreset", v_nreset, 1'b1);
        check_eq("v sw E+2 ready", v_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised multi-domain reset generator that replaces the single-output reset synchroniser between the board reset pin and the core. It asserts all `CHANNELS` active-low reset outputs immediately and asynchronously on `reset_n` low. After `reset_n` rises it synchronises the release, waits a hold-off, and releases the channels one at a time in ascending order with a fixed gap. It also supports software-requested re-reset of a selected subset of channels without disturbing the rest.

## Interface
- `CHANNELS`, 4: number of reset outputs, 1..32.
- `SYNC_STAGES`, 2: synchroniser flops on the `reset_n` release path, at least 2.
- `HOLDOFF_CYCLES`, 4: cycles the synchronised reset must be high before the first release; also the software-reset hold time; at least 1.
- `RELEASE_GAP`, 16: cycles between consecutive channel releases; at least 1.
- `clk` in 1: single clock for all logic.
- `reset_n` in 1: raw reset. Asynchronous, active-low.
- `sw_reset_req` in 1: software reset request, level-sampled on `clk`.
- `sw_reset_mask` in CHANNELS: channels to re-reset, sampled with `sw_reset_req`.
- `nreset` out CHANNELS: active-low resets; bit 0 is released first.
- `ready` out 1: high when every channel is released and the block is idle.

## Operation
- All flops are asynchronously cleared by `reset_n` low.
  - Reset values: `nreset` = all 0, `ready` = 0, synchroniser = 0, counters = 0, state = SYNC.
- Assertion is asynchronous. Release is always synchronous to the rising edge of `clk`.
- States:
  - SYNC: wait for the synchroniser output to go high.
  - HOLDOFF: count `HOLDOFF_CYCLES` cycles, then set `nreset[0]` and go to RELEASE. The counter clears to 0 on entry.
  - RELEASE: every `RELEASE_GAP` cycles, set the next `nreset` bit. The `ready` register is set on the same edge as the final bit, then go to IDLE.
  - IDLE: `ready` = 1. If `sw_reset_req` = 1 and `sw_reset_mask` != 0 on an edge, on that edge:
    - clear `nreset[i]` for every mask bit that is 1;
    - clear `ready`;
    - latch the mask;
    - go to SW_HOLD.
  - SW_HOLD: count `HOLDOFF_CYCLES` cycles, then set the lowest latched-mask channel and go to SW_RELEASE.
  - SW_RELEASE: set the remaining latched-mask channels in ascending order, one every `RELEASE_GAP` cycles. Unmasked channels are skipped and consume no gap. `ready` is set with the last one, then go to IDLE.
- Unmasked channels hold `nreset` = 1 throughout a software sequence.
- `sw_reset_req` is ignored outside IDLE. A request with a zero mask is ignored. No request is queued.
- If `sw_reset_req` is held high, a new software sequence starts on the first edge after `ready` rises.
- `reset_n` low in any state aborts everything. The sequence then restarts from SYNC.
- Counter width is `$clog2(max(HOLDOFF_CYCLES, RELEASE_GAP)+1)`. Counters never wrap, because they clear on every state or channel step.
- `nreset` and `ready` come straight from flops, with no combinational path from inputs. The exception is the asynchronous clear.

## Timing
- Edge 1 is the first `clk` rising edge at which `reset_n` = 1 (setup and recovery met).
- The synchroniser output is high after edge `SYNC_STAGES`.
- `nreset[0]` rises at edge `SYNC_STAGES + HOLDOFF_CYCLES`.
- `nreset[k]` rises at edge `SYNC_STAGES + HOLDOFF_CYCLES + k*RELEASE_GAP`.
- `ready` rises together with `nreset[CHANNELS-1]`.
- With defaults, release edges are 6, 22, 38, 54.
- Software reset requested at edge E: the masked bits fall at E. The first masked bit rises at E+`HOLDOFF_CYCLES`, and each further masked bit `RELEASE_GAP` later.
- `reset_n` falling forces `nreset` = 0 and `ready` = 0 within propagation delay, independent of `clk`.

## Test plan
- **Defaults, power-on:** `reset_n` low 5 cycles then high → `nreset` = 0000 until edge 6. Then 0001 at edge 6, 0011 at 22, 0111 at 38, 1111 with `ready` = 1 at 54. No output change on any other edge.
- **Reset mid-sequence:** drop `reset_n` between edges 29 and 30 for 3 cycles → `nreset` = 0000 and `ready` = 0 immediately, without a clock. After `reset_n` rises, the full timing of the first scenario is repeated from the new edge 1.
- **Software reset, mask 1010:** requested at edge E in IDLE → `nreset` = 0101 after E. Bit 1 rises at E+4. Bit 3 rises at E+20 with `ready` = 1. Bits 0 and 2 stay 1 throughout.
- **Ignored requests:** `sw_reset_req` = 1 with mask 0000 in IDLE, with mask 1111 during RELEASE, and during SW_RELEASE → no deviation from the nominal release schedule, and no queued sequence afterwards.
- **Held request:** `sw_reset_req` held at 1 with mask 0001 → `nreset[0]` pulses low for 4 cycles repeatedly. `ready` is high for exactly one cycle between pulses.
- **Parameter variant:** `CHANNELS`=1, `SYNC_STAGES`=3, `HOLDOFF_CYCLES`=1, `RELEASE_GAP`=1 → `nreset[0]` and `ready` rise at edge 4. A software request at E gives `nreset[0]` low for exactly one cycle, high again at E+1.
